ps2_keyb_fifo: RTL and testbench

Parametrised successor to the single-scancode keyboard register block. It buffers decoded PS/2 keyboard events in a FIFO of configurable depth, so that the CPU no longer loses codes that arrive between polls. Events are presented through the ZX-UNO register interface as SCANCODE/KBSTATUS, with overflow reporting, a FIFO flush command and a configurable hotkey pulse. It sits between ps2_port (event source) and the ZX-UNO register read mux.

---
 rtl/ps2_keyb_fifo.sv | 257 +++++++++++++++++++++++++
 tb/tb_ps2_keyb_fifo.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyb_fifo.sv
// ---------------------------------------------------------------------------
// ps2_keyb_fifo
//
// Keyboard event buffer for the ZX-UNO register interface. Decoded PS/2
// events from ps2_port are queued in a FIFO of 2^DEPTH_LOG2 entries, so codes
// arriving between CPU polls are no longer lost. The head entry is exposed
// through the SCANCODE register; KBSTATUS carries status flags and accepts a
// flush command. A one-cycle hotkey pulse is raised for HOTKEY_CODE makes.
//
// Optional feature (compile-time macro):
//   PS2_KEYB_FIFO_TYPEMATIC_FILTER_EN - when defined, repeated makes of the
//   same key (typematic auto-repeat) are discarded until a break or a make
//   of a different key is seen. When undefined every event is queued.
//
// Parameters:
//   SCANCODE    register address of the head scancode (read)
//   KBSTATUS    register address of status (read) / command (write)
//   DEPTH_LOG2  log2 of FIFO depth, legal range 1..6
//   HOTKEY_CODE non-extended make code that fires hotkey_pulse
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   scan_valid          one-cycle strobe: new event from ps2_port
//   scan_code/ext/rls   event code, E0 prefix seen, F0 prefix seen
//   ps2busy, kberror    host-to-keyboard transmitter busy / error
//   zxuno_addr/regrd/regwr/din   ZX-UNO register bus
//   scancode_dout       head code (combinational), 0 when empty
//   oe_n_scancode       low while SCANCODE is being read
//   kbstatus_dout       registered status BSY|OVF|FULL|0|ERR|RLS|EXT|PEN
//   oe_n_kbstatus       low while KBSTATUS is being read
//   hotkey_pulse        one-cycle pulse after a HOTKEY_CODE make
//   fifo_level          number of stored entries
// ---------------------------------------------------------------------------
module ps2_keyb_fifo #(
    parameter logic [7:0] SCANCODE    = 8'h04,
    parameter logic [7:0] KBSTATUS    = 8'h05,
    parameter int         DEPTH_LOG2  = 4,
    parameter logic [7:0] HOTKEY_CODE = 8'h7E
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_valid,
    input  logic [7:0]            scan_code,
    input  logic                  scan_ext,
    input  logic                  scan_rls,
    input  logic                  ps2busy,
    input  logic                  kberror,
    input  logic [7:0]            zxuno_addr,
    input  logic                  zxuno_regrd,
    input  logic                  zxuno_regwr,
    input  logic [7:0]            din,
    output logic [7:0]            scancode_dout,
    output logic                  oe_n_scancode,
    output logic [7:0]            kbstatus_dout,
    output logic                  oe_n_kbstatus,
    output logic                  hotkey_pulse,
    output logic [DEPTH_LOG2:0]   fifo_level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam ptr_t PTR_ONE  = ptr_t'(1);

    // Entry layout: {rls, ext, code}
    logic [9:0] mem_q [DEPTH];

    ptr_t       rd_ptr_q, rd_ptr_d;
    ptr_t       wr_ptr_q, wr_ptr_d;
    cnt_t       cnt_q, cnt_d;
    logic       ovf_q, ovf_d;
    logic       rd_sc_q;
    logic       rd_ks_q;
    logic [7:0] kbstatus_q, kbstatus_d;
    logic       hotkey_q, hotkey_d;

    logic       rd_sc;
    logic       rd_ks;
    logic       sc_end;
    logic       ks_end;
    logic       flush;
    logic       repeat_make;
    logic       push_req;
    logic       pop_ok;
    logic       push_ok;
    logic       overflow;
    logic       is_full;
    logic       mem_we;
    logic       head_vld_d;
    logic [9:0] new_entry;
    logic [9:0] head_d;

    // Only din[7] carries a command; the remaining bits are reserved.
    logic       unused_din;
    assign unused_din = ^din[6:0];

    // -----------------------------------------------------------------------
    // Register bus decode and end-of-read detection
    // -----------------------------------------------------------------------
    assign rd_sc = (zxuno_addr == SCANCODE) && zxuno_regrd;
    assign rd_ks = (zxuno_addr == KBSTATUS) && zxuno_regrd;

    assign oe_n_scancode = ~rd_sc;
    assign oe_n_kbstatus = ~rd_ks;

    // A read ends on the first cycle the strobe is gone after being present,
    // so a strobe held for many cycles still yields a single pop / clear.
    assign sc_end = rd_sc_q && !rd_sc;
    assign ks_end = rd_ks_q && !rd_ks;

    assign flush = zxuno_regwr && (zxuno_addr == KBSTATUS) && din[7];

    // -----------------------------------------------------------------------
    // Typematic filter (optional)
    // -----------------------------------------------------------------------
`ifdef PS2_KEYB_FIFO_TYPEMATIC_FILTER_EN
    logic       lm_vld_q;
    logic [8:0] lm_key_q;

    assign repeat_make = scan_valid && !scan_rls && lm_vld_q &&
                         (lm_key_q == {scan_ext, scan_code});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lm_vld_q <= 1'b0;
            lm_key_q <= '0;
        end else if (flush) begin
            lm_vld_q <= 1'b0;
        end else if (scan_valid) begin
            if (scan_rls) begin
                lm_vld_q <= 1'b0;
            end else begin
                lm_vld_q <= 1'b1;
                lm_key_q <= {scan_ext, scan_code};
            end
        end
    end
`else
    assign repeat_make = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FIFO control
    // -----------------------------------------------------------------------
    assign is_full   = (cnt_q == FULL_CNT);
    assign new_entry = {scan_rls, scan_ext, scan_code};
    assign push_req  = scan_valid && !repeat_make;
    // Popping an empty FIFO is a no-op.
    assign pop_ok    = sc_end && (cnt_q != '0);
    // A full FIFO still accepts a push when a slot frees in the same cycle.
    assign push_ok   = push_req && (!is_full || pop_ok);
    assign overflow  = push_req && is_full && !pop_ok;
    assign mem_we    = push_ok && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
            // A new overflow wins over a status-read clear in the same cycle.
            if (ks_end) begin
                ovf_d = 1'b0;
            end
            if (overflow) begin
                ovf_d = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next status byte
    // -----------------------------------------------------------------------
    // Status is built from next-state values so it tracks fifo_level with no
    // extra cycle of lag. If the next head is the slot being written this
    // cycle (FIFO was empty, or drained to it), take the incoming entry
    // directly since the memory has not been updated yet.
    always_comb begin
        head_vld_d = (cnt_d != '0);
        if (mem_we && (rd_ptr_d == wr_ptr_q)) begin
            head_d = new_entry;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        kbstatus_d = {ps2busy,
                      ovf_d,
                      (cnt_d == FULL_CNT),
                      1'b0,
                      kberror,
                      head_vld_d & head_d[9],
                      head_vld_d & head_d[8],
                      head_vld_d};
        hotkey_d = scan_valid && (scan_code == HOTKEY_CODE) &&
                   !scan_ext && !scan_rls && !repeat_make;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            rd_sc_q    <= 1'b0;
            rd_ks_q    <= 1'b0;
            kbstatus_q <= 8'h00;
            hotkey_q   <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            rd_sc_q    <= rd_sc;
            rd_ks_q    <= rd_ks;
            kbstatus_q <= kbstatus_d;
            hotkey_q   <= hotkey_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign scancode_dout = (cnt_q != '0) ? mem_q[rd_ptr_q][7:0] : 8'h00;
    assign kbstatus_dout = kbstatus_q;
    assign hotkey_pulse  = hotkey_q;
    assign fifo_level    = cnt_q;

endmodule

// File: tb/tb_ps2_keyb_fifo.sv
// ---------------------------------------------------------------------------
// Testbench for ps2_keyb_fifo (default parameters, depth 16).
// A queue-based reference model predicts every output for every cycle; the
// driver pushes the prediction into a scoreboard queue as it applies the
// stimulus and a separate monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_ps2_keyb_fifo;

    localparam int         DL2   = 4;
    localparam int         DEPTH = 16;
    localparam logic [7:0] A_SC  = 8'h04;
    localparam logic [7:0] A_KS  = 8'h05;
    localparam logic [7:0] HK    = 8'h7E;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n       = 1'b0;
    logic         scan_valid  = 1'b0;
    logic [7:0]   scan_code   = 8'h00;
    logic         scan_ext    = 1'b0;
    logic         scan_rls    = 1'b0;
    logic         ps2busy     = 1'b0;
    logic         kberror     = 1'b0;
    logic [7:0]   zxuno_addr  = 8'h00;
    logic         zxuno_regrd = 1'b0;
    logic         zxuno_regwr = 1'b0;
    logic [7:0]   din         = 8'h00;
    logic [7:0]   scancode_dout;
    logic         oe_n_scancode;
    logic [7:0]   kbstatus_dout;
    logic         oe_n_kbstatus;
    logic         hotkey_pulse;
    logic [DL2:0] fifo_level;

    ps2_keyb_fifo dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .scan_valid    (scan_valid),
        .scan_code     (scan_code),
        .scan_ext      (scan_ext),
        .scan_rls      (scan_rls),
        .ps2busy       (ps2busy),
        .kberror       (kberror),
        .zxuno_addr    (zxuno_addr),
        .zxuno_regrd   (zxuno_regrd),
        .zxuno_regwr   (zxuno_regwr),
        .din           (din),
        .scancode_dout (scancode_dout),
        .oe_n_scancode (oe_n_scancode),
        .kbstatus_dout (kbstatus_dout),
        .oe_n_kbstatus (oe_n_kbstatus),
        .hotkey_pulse  (hotkey_pulse),
        .fifo_level    (fifo_level)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0] sc;
        logic [7:0] ks;
        logic [4:0] lvl;
        logic       hk;
        logic       oe_sc;
        logic       oe_ks;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- reference model ----------------
    logic [9:0] fq[$];      // queued {rls, ext, code}
    bit         m_ovf, m_bsy, m_err, m_hk, m_prev_sc, m_prev_ks;
`ifdef PS2_KEYB_FIFO_TYPEMATIC_FILTER_EN
    bit         m_lm_vld;
    logic [8:0] m_lm;
`endif

    task automatic model_reset();
        fq.delete();
        m_ovf = 0; m_bsy = 0; m_err = 0; m_hk = 0;
        m_prev_sc = 0; m_prev_ks = 0;
`ifdef PS2_KEYB_FIFO_TYPEMATIC_FILTER_EN
        m_lm_vld = 0;
`endif
    endtask

    // Applies one rising edge given the inputs held during the closing cycle.
    task automatic model_edge();
        bit rd_sc_now, rd_ks_now, sc_end, ks_end, flush, rep;
        rd_sc_now = (zxuno_addr == A_SC) && zxuno_regrd;
        rd_ks_now = (zxuno_addr == A_KS) && zxuno_regrd;
        sc_end    = m_prev_sc && !rd_sc_now;
        ks_end    = m_prev_ks && !rd_ks_now;
        flush     = zxuno_regwr && (zxuno_addr == A_KS) && din[7];
        rep       = 0;
`ifdef PS2_KEYB_FIFO_TYPEMATIC_FILTER_EN
        rep = scan_valid && !scan_rls && m_lm_vld && (m_lm == {scan_ext, scan_code});
`endif
        m_hk = scan_valid && (scan_code == HK) && !scan_ext && !scan_rls && !rep;
        if (flush) begin
            fq.delete();
            m_ovf = 0;
`ifdef PS2_KEYB_FIFO_TYPEMATIC_FILTER_EN
            m_lm_vld = 0;
`endif
        end else begin
            if (ks_end) m_ovf = 0;
            if (sc_end && fq.size() > 0) void'(fq.pop_front());
            if (scan_valid && !rep) begin
                if (fq.size() < DEPTH) fq.push_back({scan_rls, scan_ext, scan_code});
                else m_ovf = 1;
            end
`ifdef PS2_KEYB_FIFO_TYPEMATIC_FILTER_EN
            if (scan_valid) begin
                if (scan_rls) m_lm_vld = 0;
                else begin m_lm_vld = 1; m_lm = {scan_ext, scan_code}; end
            end
`endif
        end
        m_bsy = ps2busy;
        m_err = kberror;
        m_prev_sc = rd_sc_now;
        m_prev_ks = rd_ks_now;
    endtask

    task automatic push_exp();
        exp_t       e;
        logic [9:0] head;
        bit         ne;
        ne      = fq.size() > 0;
        head    = ne ? fq[0] : 10'h000;
        e.lvl   = 5'(fq.size());
        e.sc    = head[7:0];
        e.ks    = {m_bsy, m_ovf, fq.size() == DEPTH, 1'b0, m_err, head[9], head[8], ne};
        e.hk    = m_hk;
        e.oe_sc = !((zxuno_addr == A_SC) && zxuno_regrd);
        e.oe_ks = !((zxuno_addr == A_KS) && zxuno_regrd);
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("scancode_dout", 32'(scancode_dout), 32'(e.sc));
                chk("kbstatus_dout", 32'(kbstatus_dout), 32'(e.ks));
                chk("fifo_level",    32'(fifo_level),    32'(e.lvl));
                chk("hotkey_pulse",  32'(hotkey_pulse),  32'(e.hk));
                chk("oe_n_scancode", 32'(oe_n_scancode), 32'(e.oe_sc));
                chk("oe_n_kbstatus", 32'(oe_n_kbstatus), 32'(e.oe_ks));
            end
        end
    end

    // ---------------- driver ----------------
    logic       n_rst = 1'b0, n_sv = 1'b0, n_ext = 1'b0, n_rls = 1'b0;
    logic       n_rd = 1'b0, n_wr = 1'b0, n_busy = 1'b0, n_err = 1'b0;
    logic [7:0] n_code = 8'h00, n_addr = 8'h00, n_din = 8'h00;

    // One clock cycle: model takes the edge, new inputs are applied, the
    // prediction for this cycle is queued, then outputs are allowed to settle.
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_edge();
        rst_n       = n_rst;
        scan_valid  = n_sv;
        scan_code   = n_code;
        scan_ext    = n_ext;
        scan_rls    = n_rls;
        zxuno_addr  = n_addr;
        zxuno_regrd = n_rd;
        zxuno_regwr = n_wr;
        din         = n_din;
        ps2busy     = n_busy;
        kberror     = n_err;
        if (!rst_n) model_reset();
        push_exp();
        n_sv = 0;
        n_wr = 0;
        #1;
    endtask

    task automatic push_ev(input logic [7:0] code, input logic ext, input logic rls);
        n_sv = 1; n_code = code; n_ext = ext; n_rls = rls;
        step();
        n_ext = 0; n_rls = 0;
    endtask

    // Read of len cycles; returns during the end-of-read cycle.
    task automatic rd_reg(input logic [7:0] addr, input int len);
        n_addr = addr; n_rd = 1;
        repeat (len) step();
        n_rd = 0;
        step();
    endtask

    task automatic flush_fifo();
        n_addr = A_KS; n_wr = 1; n_din = 8'h80;
        step();
    endtask

    initial begin
        logic [7:0] k;
        model_reset();

        // Reset state
        step(); step();
        chk("reset_level", 32'(fifo_level), 32'd0);
        chk("reset_kbstatus", 32'(kbstatus_dout), 32'h00);
        chk("reset_hotkey", 32'(hotkey_pulse), 32'd0);
        n_rst = 1; step();

        // Make then break of 0x1C
        push_ev(8'h1C, 0, 0);
        push_ev(8'h1C, 0, 1);
        step();
        chk("mk_brk_level", 32'(fifo_level), 32'd2);
        n_addr = A_SC; n_rd = 1; step();
        chk("mk_read_code", 32'(scancode_dout), 32'h1C);
        chk("mk_read_status", 32'(kbstatus_dout), 32'h01);
        n_rd = 0; step(); step();
        chk("brk_head_code", 32'(scancode_dout), 32'h1C);
        chk("brk_head_status", 32'(kbstatus_dout), 32'h05);
        rd_reg(A_SC, 1); step();
        chk("drained_level", 32'(fifo_level), 32'd0);

        // Overflow: 17 pushes into 16 slots
        for (int i = 0; i < 17; i++) push_ev(8'h30 + 8'(i), 0, 0);
        step();
        chk("ovf_level", 32'(fifo_level), 32'd16);
        chk("ovf_status", 32'(kbstatus_dout), 32'h61);
        rd_reg(A_KS, 2);
        chk("ovf_before_clear", 32'(kbstatus_dout[6]), 32'd1);
        step();
        chk("ovf_cleared", 32'(kbstatus_dout[6]), 32'd0);

        // Full FIFO: push on the SCANCODE end-of-read cycle
        n_addr = A_SC; n_rd = 1; step();
        n_rd = 0; n_sv = 1; n_code = 8'h55; step();
        step();
        chk("full_pushpop_level", 32'(fifo_level), 32'd16);
        chk("full_pushpop_ovf", 32'(kbstatus_dout[6]), 32'd0);
        for (int i = 0; i < 16; i++) begin
            n_addr = A_SC; n_rd = 1; step();
            if (i == 0)  chk("drain_first", 32'(scancode_dout), 32'h31);
            if (i == 15) chk("drain_last", 32'(scancode_dout), 32'h55);
            n_rd = 0; step();
        end
        step();
        chk("drain_level", 32'(fifo_level), 32'd0);

        // Long read pops once; empty read returns 0
        push_ev(8'h11, 0, 0); push_ev(8'h12, 1, 0); push_ev(8'h13, 0, 0);
        step();
        n_addr = A_SC; n_rd = 1; repeat (5) step();
        n_rd = 0; step(); step();
        chk("long_read_level", 32'(fifo_level), 32'd2);
        rd_reg(A_SC, 1); rd_reg(A_SC, 1); step();
        n_rd = 1; step();
        chk("empty_read_code", 32'(scancode_dout), 32'h00);
        n_rd = 0; step(); step();
        chk("empty_read_level", 32'(fifo_level), 32'd0);

        // Hotkey
        push_ev(HK, 0, 0);
        chk("hk_same_cycle", 32'(hotkey_pulse), 32'd0);
        step();
        chk("hk_pulse", 32'(hotkey_pulse), 32'd1);
        step();
        chk("hk_one_cycle", 32'(hotkey_pulse), 32'd0);
        push_ev(HK, 1, 0); step();
        chk("hk_ext", 32'(hotkey_pulse), 32'd0);
        push_ev(HK, 0, 1); step();
        chk("hk_rls", 32'(hotkey_pulse), 32'd0);

        // Flush with 3 queued entries
        chk("pre_flush_level", 32'(fifo_level), 32'd3);
        flush_fifo(); step();
        chk("flush_level", 32'(fifo_level), 32'd0);
        chk("flush_pen", 32'(kbstatus_dout[0]), 32'd0);

        // Reset in the middle of a read
        push_ev(8'h21, 0, 0); push_ev(8'h22, 0, 0);
        n_addr = A_SC; n_rd = 1; step(); step();
        n_rst = 0; step();
        chk("midrd_rst_level", 32'(fifo_level), 32'd0);
        chk("midrd_rst_status", 32'(kbstatus_dout), 32'h00);
        step();
        n_rst = 1; n_rd = 0; step();
        push_ev(8'h23, 0, 0); step(); step();
        chk("post_rst_level", 32'(fifo_level), 32'd1);
        flush_fifo(); step();

        // Typematic repeats
        push_ev(8'h1C, 0, 0); push_ev(8'h1C, 0, 0); push_ev(8'h1C, 0, 0);
        push_ev(8'h1C, 0, 1); step();
`ifdef PS2_KEYB_FIFO_TYPEMATIC_FILTER_EN
        chk("typematic_level", 32'(fifo_level), 32'd2);
`else
        chk("typematic_level", 32'(fifo_level), 32'd4);
`endif
        flush_fifo(); step();

        // Randomised traffic
        for (int c = 0; c < 4000; c++) begin
            bit push_heavy;
            push_heavy = ((c / 400) % 2) == 0;
            n_sv = push_heavy ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0: k = HK;
                1: k = 8'h1C;
                2: k = 8'h5A;
                default: k = 8'($urandom);
            endcase
            n_code = k;
            n_ext  = ($urandom_range(0, 3) == 0);
            n_rls  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1: n_addr = A_SC;
                    2:    n_addr = A_KS;
                    default: n_addr = 8'h10;
                endcase
            end
            n_rd   = push_heavy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
            n_wr   = ($urandom_range(0, 59) == 0);
            n_din  = 8'($urandom);
            n_busy = ($urandom_range(0, 7) == 0);
            n_err  = ($urandom_range(0, 7) == 0);
            n_rst  = !($urandom_range(0, 499) == 0);
            step();
        end

        n_rst = 1; n_rd = 0; n_sv = 0;
        step(); step();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
